// File: rtl/audio_sample_fetcher.sv
// audio_sample_fetcher: streams 16-bit PCM words from SDRAM into a
// prefetch FIFO and hands one sample to the codec per sample tick.
module audio_sample_fetcher #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 26
) (
  input  logic              clock_12,
  input  logic              reset_12_n,
  input  logic              enable,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] address,
  output logic              request,
  input  logic              done,
  input  logic [15:0]       readdata,
  input  logic              sample_tick,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              playing
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] EVEN = ~ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, REQ, LAST, DRAIN, ABORT
  } state_t;

  state_t state, state_d;

  logic              enable_q;
  logic [ADDR_W-1:0] start_q, end_q, cur_addr;
  logic [ADDR_W-1:0] start_d, end_d, cur_d, addr_d;
  logic [ADDR_W-1:0] s_even, e_even;
  logic              req_d, play_d, flush;
  logic              push, pop, starve;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;

  assign s_even = start_addr & EVEN;
  assign e_even = end_addr & EVEN;

  // data of a read finished after enable fell is dropped here
  assign push   = (state == REQ || state == LAST)
                  && request && done && enable;
  assign pop    = sample_tick && playing && (count != '0);
  assign starve = sample_tick && playing && (count == '0);

  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + (PW+1)'(1);
    else if (pop && !push) count_next = count - (PW+1)'(1);
  end

  always_comb begin
    state_d = state;
    start_d = start_q;
    end_d   = end_q;
    cur_d   = cur_addr;
    addr_d  = address;
    req_d   = request;
    play_d  = playing;
    flush   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !enable_q) begin
          start_d = s_even;
          end_d   = e_even;
          cur_d   = s_even;
          addr_d  = s_even;
          req_d   = 1'b1;
          play_d  = 1'b1;
          state_d = (s_even >= e_even) ? LAST : REQ;
        end
      end
      REQ, LAST: begin
        if (!enable) begin
          play_d = 1'b0;
          if (request && !done) begin
            state_d = ABORT;
          end else begin
            req_d   = 1'b0;
            flush   = 1'b1;
            state_d = IDLE;
          end
        end else if (request) begin
          if (done) begin
            req_d = 1'b0;
            if (state == LAST) begin
              if (loop) begin
                cur_d   = start_q;
                state_d = REQ;
              end else begin
                state_d = DRAIN;
              end
            end else begin
              cur_d = cur_addr + ADDR_W'(2);
            end
          end
        end else if (count < FULL) begin
          req_d  = 1'b1;
          addr_d = cur_addr;
          if (cur_addr >= end_q) state_d = LAST;
        end
      end
      DRAIN: begin
        if (!enable || count_next == '0) begin
          play_d  = 1'b0;
          flush   = !enable;
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (done) begin
          req_d   = 1'b0;
          flush   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_12 or negedge reset_12_n) begin
    if (!reset_12_n) begin
      state        <= IDLE;
      enable_q     <= 1'b0;
      start_q      <= '0;
      end_q        <= '0;
      cur_addr     <= '0;
      address      <= '0;
      request      <= 1'b0;
      playing      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_d;
      enable_q     <= enable;
      start_q      <= start_d;
      end_q        <= end_d;
      cur_addr     <= cur_d;
      address      <= addr_d;
      request      <= req_d;
      playing      <= play_d;
      sample_valid <= pop;
      underrun     <= starve;
      if (pop) sample_out <= mem[rd_ptr];
      else if (starve) sample_out <= '0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count_next;
      end
    end
  end

  always_ff @(posedge clock_12) begin
    if (push) mem[wr_ptr] <= readdata;
  end

  a_no_overflow: assert property (
    @(posedge clock_12) disable iff (!reset_12_n)
    !(push && count == FULL));

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Bench for audio_sample_fetcher: queue-based playback model plus
// directed scenarios with literal expectations.
module tb_audio_sample_fetcher;
  localparam int DEPTH = 8;
  localparam int AW = 26;

  logic clock_12 = 1'b0;
  logic reset_12_n = 1'b0;
  logic enable = 1'b0;
  logic loop = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [AW-1:0] address;
  logic request;
  logic done = 1'b0;
  logic [15:0] readdata = '0;
  logic sample_tick = 1'b0;
  logic [15:0] sample_out;
  logic sample_valid, underrun, playing;

  audio_sample_fetcher #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock_12(clock_12), .reset_12_n(reset_12_n),
    .enable(enable), .loop(loop),
    .start_addr(start_addr), .end_addr(end_addr),
    .address(address), .request(request),
    .done(done), .readdata(readdata),
    .sample_tick(sample_tick), .sample_out(sample_out),
    .sample_valid(sample_valid), .underrun(underrun),
    .playing(playing)
  );

  always #5 clock_12 = ~clock_12;

  int tests = 0;
  int fails = 0;
  int lat = 3;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // bridge: answers each request after lat cycles with the address as data
  int wcnt = 0;
  initial begin
    forever begin
      @(posedge clock_12);
      #1;
      if (!reset_12_n) begin
        done = 1'b0;
        wcnt = 0;
      end else if (done) begin
        done = 1'b0;
      end else if (request) begin
        wcnt++;
        if (wcnt >= lat) begin
          done = 1'b1;
          readdata = address[15:0];
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // playback model: queue of fetched words, expected outputs per edge
  logic [15:0] mq[$];
  logic m_play, m_ended, m_en_q, m_done_edge;
  logic e_valid, e_under;
  logic [15:0] e_out;
  logic [AW-1:0] m_start, m_end, m_cur;

  always @(posedge clock_12 or negedge reset_12_n) begin
    if (!reset_12_n) begin
      mq.delete();
      m_play = 0; m_ended = 0; m_en_q = 0; m_done_edge = 0;
      e_valid = 0; e_under = 0; e_out = '0;
      m_start = '0; m_end = '0; m_cur = '0;
    end else begin
      e_valid = 0;
      e_under = 0;
      m_done_edge = done;
      if (sample_tick && m_play) begin
        if (mq.size() > 0) begin
          e_out = mq.pop_front();
          e_valid = 1;
        end else begin
          e_out = '0;
          e_under = 1;
        end
      end
      if (done && enable && m_play && !m_ended) begin
        mq.push_back(readdata);
        if (m_cur >= m_end) begin
          if (loop) m_cur = m_start;
          else m_ended = 1;
        end else begin
          m_cur = m_cur + AW'(2);
        end
      end
      if (!enable && m_play) begin
        m_play = 0;
        mq.delete();
      end else if (enable && !m_en_q && !m_play) begin
        m_play = 1;
        m_start = start_addr & ~AW'(1);
        m_end = end_addr & ~AW'(1);
        m_cur = m_start;
        m_ended = 0;
        mq.delete();
      end else if (m_play && m_ended && mq.size() == 0) begin
        m_play = 0;
      end
      m_en_q = enable;
    end
  end

  // compare process
  logic req_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  int n_valid = 0, n_under = 0, n_req = 0;
  logic [15:0] cap[$];
  logic [AW-1:0] alog[$];

  always @(negedge clock_12) begin
    if (reset_12_n) begin
      chk("sample_valid", 32'(sample_valid), 32'(e_valid));
      chk("underrun", 32'(underrun), 32'(e_under));
      chk("playing", 32'(playing), 32'(m_play));
      chk("sample_out", 32'(sample_out), 32'(e_out));
      if (sample_valid) begin
        n_valid++;
        cap.push_back(sample_out);
      end
      if (underrun) n_under++;
      if (request && !req_prev) begin
        n_req++;
        alog.push_back(address);
        chk("req_addr", 32'(address), 32'(m_cur));
        chk("req_allowed",
            32'(m_play && !m_ended && mq.size() < DEPTH), 32'(1));
      end
      if (request && req_prev)
        chk("req_stable", 32'(address), 32'(addr_prev));
      if (!request && req_prev)
        chk("req_drop_on_done", 32'(m_done_edge), 32'(1));
      req_prev = request;
      addr_prev = address;
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_12);
      #2;
    end
  endtask

  task automatic ticks(input int period, input int n);
    repeat (n) begin
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(period - 1);
    end
  endtask

  task automatic clr();
    n_valid = 0;
    n_under = 0;
    n_req = 0;
    cap.delete();
    alog.delete();
  endtask

  task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] e,
                    input logic l);
    start_addr = s;
    end_addr = e;
    loop = l;
    enable = 1'b1;
  endtask

  task automatic stop();
    enable = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!request) break;
      cyc(1);
    end
    chk("stop_req_low", 32'(request), 32'(0));
    cyc(3);
  endtask

  function automatic logic [31:0] capv(input int i);
    return (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] alogv(input int i);
    return (i < alog.size()) ? 32'(alog[i]) : 32'hDEAD;
  endfunction

  initial begin
    cyc(3);
    chk("rst_address", 32'(address), 32'(0));
    chk("rst_request", 32'(request), 32'(0));
    chk("rst_sample_out", 32'(sample_out), 32'(0));
    chk("rst_valid", 32'(sample_valid), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    chk("rst_playing", 32'(playing), 32'(0));
    reset_12_n = 1'b1;
    cyc(2);

    // one-shot playback
    lat = 3;
    clr();
    go(26'h100, 26'h10E, 1'b0);
    cyc(10);
    ticks(20, 12);
    chk("oneshot_count", 32'(n_valid), 32'(8));
    for (int i = 0; i < 8; i++)
      chk("oneshot_data", capv(i), 32'h100 + 32'(2 * i));
    chk("oneshot_playing", 32'(playing), 32'(0));
    chk("oneshot_underrun", 32'(n_under), 32'(0));
    cyc(30);
    chk("oneshot_reqs", 32'(n_req), 32'(8));
    stop();

    // looped playback
    clr();
    go(26'h200, 26'h204, 1'b1);
    cyc(10);
    ticks(20, 12);
    chk("loop_underrun", 32'(n_under), 32'(0));
    chk("loop_count", 32'(n_valid), 32'(12));
    for (int i = 0; i < 9; i++)
      chk("loop_addr", alogv(i), 32'h200 + 32'(2 * (i % 3)));
    for (int i = 0; i < 12; i++)
      chk("loop_data", capv(i), 32'h200 + 32'(2 * (i % 3)));
    stop();

    // backpressure
    clr();
    go(26'h1000, 26'h1FFE, 1'b0);
    cyc(100);
    chk("bp_reqs_full", 32'(n_req), 32'(DEPTH));
    chk("bp_req_low", 32'(request), 32'(0));
    ticks(1, 1);
    cyc(30);
    chk("bp_reqs_after_tick", 32'(n_req), 32'(DEPTH + 1));
    chk("bp_one_sample", 32'(n_valid), 32'(1));
    chk("bp_sample", capv(0), 32'h1000);
    stop();

    // underrun with slow bridge
    lat = 40;
    clr();
    go(26'h300, 26'h306, 1'b0);
    ticks(10, 25);
    chk("ur_count", 32'(n_valid), 32'(4));
    for (int i = 0; i < 4; i++)
      chk("ur_data", capv(i), 32'h300 + 32'(2 * i));
    chk("ur_seen", 32'(n_under > 0), 32'(1));
    chk("ur_playing", 32'(playing), 32'(0));
    stop();

    // abort mid-read
    lat = 6;
    clr();
    go(26'h500, 26'h50E, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (request) break;
      cyc(1);
    end
    chk("ab_req_rise", 32'(request), 32'(1));
    cyc(1);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      chk("ab_hold", 32'(request), 32'(1));
      cyc(1);
    end
    chk("ab_done", 32'(done), 32'(1));
    chk("ab_addr", 32'(address), 32'h500);
    cyc(2);
    chk("ab_playing", 32'(playing), 32'(0));
    chk("ab_req_low", 32'(request), 32'(0));
    chk("ab_no_sample", 32'(n_valid), 32'(0));
    cyc(20);
    chk("ab_one_req", 32'(n_req), 32'(1));
    lat = 3;
    clr();
    go(26'h580, 26'h582, 1'b0);
    cyc(10);
    ticks(20, 4);
    chk("ab_restart_count", 32'(n_valid), 32'(2));
    chk("ab_restart_d0", capv(0), 32'h580);
    chk("ab_restart_d1", capv(1), 32'h582);
    stop();

    // reset mid-playback
    clr();
    go(26'h400, 26'h4FE, 1'b0);
    for (int k = 0; k < 60; k++) begin
      if (mq.size() >= 5) break;
      cyc(1);
    end
    chk("rs_buffered", 32'(mq.size() >= 5), 32'(1));
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    #1;
    reset_12_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("rs_address", 32'(address), 32'(0));
    chk("rs_request", 32'(request), 32'(0));
    chk("rs_sample_out", 32'(sample_out), 32'(0));
    chk("rs_valid", 32'(sample_valid), 32'(0));
    chk("rs_underrun", 32'(underrun), 32'(0));
    chk("rs_playing", 32'(playing), 32'(0));
    cyc(3);
    reset_12_n = 1'b1;
    cyc(3);
    clr();
    go(26'h600, 26'h602, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (request) break;
      cyc(1);
    end
    chk("rs_restart_addr", 32'(address), 32'h600);
    cyc(10);
    ticks(20, 4);
    chk("rs_restart_count", 32'(n_valid), 32'(2));
    chk("rs_restart_d0", capv(0), 32'h600);
    stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
